// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the parametrised register file.
//   XLEN_DEF / NREGS_DEF / NRD_DEF : default data width, register count, read ports
//   X0                             : RV32I index of the hard-wired zero register
//   clog2()                        : ceiling log2, used to size register addresses
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

    localparam int X0 = 0;

    // Constant function: usable in parameter and port declarations.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one pending-write bit per architectural register.
//   clk, rst   : rising-edge clock, asynchronous active-high reset (clears all bits)
//   flush      : clear every pending bit; overrides set and clear this cycle
//   sb_set     : mark sb_addr pending (new writer issued by decode)
//   sb_addr    : destination register of the issuing instruction
//   we, waddr  : writeback completes, clear the pending bit of waddr
//   pend       : full pending vector, used by the parent for rbusy
//   any_busy   : OR of all pending bits (registered state only)
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             sb_set,
    input  logic [AW-1:0]    sb_addr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    output logic [NREGS-1:0] pend,
    output logic             any_busy
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    // Register 0 can never become pending when it is the hard-wired zero.
    logic set_ok;
    assign set_ok = sb_set && !((ZERO_REG != 0) && (sb_addr == AW'(X0)));

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path through the block leaves it unassigned (no latch).
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else begin
            if (we) begin
                pend_d[waddr] = 1'b0;
            end
            // Applied after the clear: a same-address issue wins because the
            // newly issued instruction is now the outstanding writer.
            if (set_ok) begin
                pend_d[sb_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its inputs from before the edge.
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend     = pend_q;
    assign any_busy = |pend_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with write-to-read bypass and
// a pending-write scoreboard for RAW / load-use hazard detection in decode.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   we        : writeback write enable
//   waddr     : writeback register index
//   wdata     : writeback data
//   raddr     : NRD packed read addresses, port k at [k*AW +: AW]
//   rdata     : NRD packed read data, port k at [k*XLEN +: XLEN] (combinational)
//   rbusy     : per read port, addressed register has a pending write
//   sb_set    : decode issue, mark sb_addr pending
//   sb_addr   : destination register of the issuing instruction
//   flush     : clear all pending bits
//   any_busy  : at least one register has a pending write
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREGS    = NREGS_DEF,
    parameter  int NRD      = NRD_DEF,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]    rbusy,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_addr,
    input  logic              flush,
    output logic              any_busy
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] pend;
    logic [AW-1:0]    ra [NRD];

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    regfile_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .we       (we),
        .waddr    (waddr),
        .pend     (pend),
        .any_busy (any_busy)
    );

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic write_ok;
    assign write_ok = we && !((ZERO_REG != 0) && (waddr == AW'(X0)));

    always_comb begin
        regs_d = regs_q;
        if (write_ok) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the array is deliberately reset: every register must read
            // zero while rst is high, so this stays flops rather than an SRAM.
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // Read ports with bypass and busy gating
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NRD; k++) begin : g_ra
        assign ra[k] = raddr[k*AW +: AW];
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < NRD; k++) begin
            // Reset gating also suppresses the bypass path, which would
            // otherwise forward wdata while the array is held at zero.
            if (rst) begin
                rdata[k*XLEN +: XLEN] = '0;
                rbusy[k]              = 1'b0;
            end else if ((ZERO_REG != 0) && (ra[k] == AW'(X0))) begin
                rdata[k*XLEN +: XLEN] = '0;
                rbusy[k]              = 1'b0;
            end else if ((BYPASS != 0) && we && (waddr == ra[k])) begin
                // Value arrives this cycle, so the consumer need not stall.
                rdata[k*XLEN +: XLEN] = wdata;
                rbusy[k]              = 1'b0;
            end else begin
                rdata[k*XLEN +: XLEN] = regs_q[ra[k]];
                rbusy[k]              = pend[ra[k]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized + directed bench for regfile_sb. Two instances
// (BYPASS=1 and BYPASS=0, both NRD=3) share stimulus and are compared every
// cycle against an array-based model of the register file and pending bits.
module tb_regfile_sb;

    localparam int XL = 32;
    localparam int NR = 32;
    localparam int ND = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            we = 1'b0;
    logic [4:0]      waddr = '0;
    logic [31:0]     wdata = '0;
    logic            sb_set = 1'b0;
    logic [4:0]      sb_addr = '0;
    logic            flush = 1'b0;
    logic [4:0]      ra [ND];
    logic [ND*5-1:0] raddr;

    logic [ND*XL-1:0] rdata_b, rdata_n;
    logic [ND-1:0]    rbusy_b, rbusy_n;
    logic             any_b, any_n;

    assign raddr = {ra[2], ra[1], ra[0]};

    regfile_sb #(.XLEN(XL), .NREGS(NR), .NRD(ND), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush), .any_busy(any_b)
    );

    regfile_sb #(.XLEN(XL), .NREGS(NR), .NRD(ND), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush), .any_busy(any_n)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: architectural registers and pending bits
    // ------------------------------------------------------------------
    logic [31:0] mem  [NR];
    bit          pend [NR];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                mem[i]  <= '0;
                pend[i] <= 1'b0;
            end
        end else begin
            if (we && waddr != 0) mem[waddr] <= wdata;
            if (flush) begin
                for (int i = 0; i < NR; i++) pend[i] <= 1'b0;
            end else begin
                if (we) pend[waddr] <= 1'b0;
                // Later NBA wins: issue on the same register leaves it pending.
                if (sb_set && sb_addr != 0) pend[sb_addr] <= 1'b1;
            end
        end
    end

    function automatic logic [31:0] exp_rdata(input bit bp, input logic [4:0] a);
        if (rst || a == 0) return 32'h0;
        if (bp && we && waddr == a) return wdata;
        return mem[a];
    endfunction

    function automatic logic exp_rbusy(input bit bp, input logic [4:0] a);
        if (rst || a == 0) return 1'b0;
        if (bp && we && waddr == a) return 1'b0;
        return pend[a];
    endfunction

    function automatic logic exp_any();
        if (rst) return 1'b0;
        for (int i = 0; i < NR; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Per-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < ND; k++) begin
                check($sformatf("rdata_byp[%0d]", k), 96'(rdata_b[k*XL +: XL]), 96'(exp_rdata(1'b1, ra[k])));
                check($sformatf("rdata_nobyp[%0d]", k), 96'(rdata_n[k*XL +: XL]), 96'(exp_rdata(1'b0, ra[k])));
                check($sformatf("rbusy_byp[%0d]", k), 96'(rbusy_b[k]), 96'(exp_rbusy(1'b1, ra[k])));
                check($sformatf("rbusy_nobyp[%0d]", k), 96'(rbusy_n[k]), 96'(exp_rbusy(1'b0, ra[k])));
            end
            check("any_busy_byp", 96'(any_b), 96'(exp_any()));
            check("any_busy_nobyp", 96'(any_n), 96'(exp_any()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; sb_set = 1'b0; flush = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < ND; k++) ra[k] = '0;
        #1 rst = 1'b1;
        step();
        chk_en = 1'b1;
        #1;
        check("reset_rdata", 96'(rdata_b), 96'h0);
        check("reset_any_busy", 96'(any_b), 96'h0);
        step();
        rst = 1'b0;

        // Async reset mid-cycle after writing reg5.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; sb_set = 1'b1; sb_addr = 5'd2;
        step();
        idle(); ra[0] = 5'd5;
        #1;
        check("pre_reset_read5", 96'(rdata_b[31:0]), 96'hDEAD_BEEF);
        check("pre_reset_any_busy", 96'(any_b), 96'h1);
        #1 rst = 1'b1;
        #1;
        check("async_reset_read5", 96'(rdata_b[31:0]), 96'h0);
        check("async_reset_any_busy", 96'(any_b), 96'h0);
        step();
        rst = 1'b0;

        // Write then read on two ports; writes to x0 are dropped.
        we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
        step();
        idle(); ra[0] = 5'd7; ra[1] = 5'd7;
        #1;
        check("read7_port0", 96'(rdata_b[31:0]), 96'h1234_5678);
        check("read7_port1", 96'(rdata_b[63:32]), 96'h1234_5678);
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; ra[0] = 5'd0;
        step();
        idle();
        #1;
        check("read_x0", 96'(rdata_b[31:0]), 96'h0);

        // Bypass versus stored value.
        we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_A5A5; ra[0] = 5'd3;
        #1;
        check("bypass_on", 96'(rdata_b[31:0]), 96'hA5A5_A5A5);
        check("bypass_off", 96'(rdata_n[31:0]), 96'h0);
        step();
        idle();

        // Scoreboard set, bypassed clear, set+clear same address.
        sb_set = 1'b1; sb_addr = 5'd9; ra[0] = 5'd9;
        step();
        idle();
        #1;
        check("sb_busy9", 96'(rbusy_b[0]), 96'h1);
        check("sb_any_busy", 96'(any_b), 96'h1);
        we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0099;
        #1;
        check("sb_wb_bypass_busy", 96'(rbusy_b[0]), 96'h0);
        check("sb_wb_nobypass_busy", 96'(rbusy_n[0]), 96'h1);
        step();
        idle();
        #1;
        check("sb_cleared9", 96'(rbusy_b[0]), 96'h0);
        check("sb_cleared_any", 96'(any_b), 96'h0);
        sb_set = 1'b1; sb_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0077;
        step();
        idle();
        #1;
        check("sb_set_wins9", 96'(rbusy_b[0]), 96'h1);

        // Flush beats set and clear; the write still lands.
        sb_set = 1'b1; sb_addr = 5'd4;
        step();
        sb_addr = 5'd6;
        step();
        idle();
        flush = 1'b1; sb_set = 1'b1; sb_addr = 5'd10;
        we = 1'b1; waddr = 5'd4; wdata = 32'h0000_0042;
        step();
        idle(); ra[0] = 5'd4; ra[1] = 5'd10;
        #1;
        check("flush_any_busy", 96'(any_b), 96'h0);
        check("flush_write4", 96'(rdata_b[31:0]), 96'h0000_0042);
        check("flush_busy10", 96'(rbusy_b[1]), 96'h0);

        // Three ports: x0, x1, x31.
        we = 1'b1; waddr = 5'd1; wdata = 32'd11;
        step();
        waddr = 5'd31; wdata = 32'd31;
        step();
        idle(); ra[0] = 5'd0; ra[1] = 5'd1; ra[2] = 5'd31;
        #1;
        check("multiport_rdata", rdata_b, {32'd31, 32'd11, 32'd0});
        sb_set = 1'b1; sb_addr = 5'd0;
        step();
        idle();
        #1;
        check("x0_never_busy", 96'(rbusy_b), 96'h0);
        check("x0_any_busy", 96'(any_b), 96'h0);

        // Randomized traffic on a small address pool to force collisions.
        for (int n = 0; n < 500; n++) begin
            step();
            rst     = ($urandom_range(0, 99) < 2);
            we      = 1'($urandom_range(0, 1));
            waddr   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wdata   = $urandom;
            sb_set  = ($urandom_range(0, 2) == 0);
            sb_addr = ($urandom_range(0, 1) == 0) ? waddr : 5'($urandom_range(0, 7));
            flush   = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < ND; k++) begin
                ra[k] = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 7));
            end
        end
        step();
        rst = 1'b0;
        idle();
        step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
